// File: rtl/u_rec_fifo.sv
// Receive buffer behind the UART receiver: turns each completed byte (a rising edge of
// rec_readyH after a long enough low period) into a write of a first-word-fall-through FIFO.
module u_rec_fifo #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int MIN_LOW = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_l,
    input  logic [7:0]        rec_dataH,
    input  logic              rec_readyH,
    input  logic              rd_enH,
    output logic [7:0]        fifo_dataH,
    output logic              fifo_emptyH,
    output logic              fifo_fullH,
    output logic [ADDR_W:0]   fifo_countH,
    output logic              overflowH,
    input  logic              clr_ovfH,
    output logic [7:0]        drop_cntH
);

    localparam logic [7:0]      MIN_LOW_C = 8'(MIN_LOW);
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);

    logic              ready_q, ready_d;
    logic [7:0]        low_cnt_q, low_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic [7:0]        mem_q [DEPTH];

    logic              rise;
    logic              wr_req;
    logic              full;
    logic              empty;
    logic              rd_en_eff;
    logic              wr_en;
    logic              drop;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign rise      = rec_readyH & ~ready_q;
    // low_cnt_q is the pre-update value, so a rise right after a short low pulse is rejected.
    assign wr_req    = rise & (low_cnt_q >= MIN_LOW_C);
    assign rd_en_eff = rd_enH & ~empty;
    // A full FIFO still accepts the byte when the head is popped on the same edge.
    assign wr_en     = wr_req & (~full | rd_en_eff);
    assign drop      = wr_req & full & ~rd_en_eff;

    always_comb begin
        ready_d    = rec_readyH;
        low_cnt_d  = low_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (rec_readyH) begin
            low_cnt_d = '0;
        end else if (low_cnt_q < MIN_LOW_C) begin
            low_cnt_d = low_cnt_q + 8'd1;
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (wr_en && !rd_en_eff) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && rd_en_eff) begin
            count_d = count_q - 1'b1;
        end

        // A drop in the same cycle as a clear wins and starts the count again at one.
        if (clr_ovfH) begin
            overflow_d = drop;
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            ready_q    <= 1'b1;
            low_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ready_q    <= ready_d;
            low_cnt_q  <= low_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; empty masks whatever it holds.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rec_dataH;
        end
    end

    assign fifo_dataH  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign fifo_emptyH = empty;
    assign fifo_fullH  = full;
    assign fifo_countH = count_q;
    assign overflowH   = overflow_q;
    assign drop_cntH   = drop_cnt_q;

endmodule

// File: tb/tb_u_rec_fifo.sv
// Bench for u_rec_fifo: reference queue of accepted bytes plus a model of the overflow state.
module tb_u_rec_fifo;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int MIN_LOW = 32;

  logic              sys_clk;
  logic              sys_rst_l;
  logic [7:0]        rec_dataH;
  logic              rec_readyH;
  logic              rd_enH;
  logic [7:0]        fifo_dataH;
  logic              fifo_emptyH;
  logic              fifo_fullH;
  logic [ADDR_W:0]   fifo_countH;
  logic              overflowH;
  logic              clr_ovfH;
  logic [7:0]        drop_cntH;

  logic [7:0] exp_q[$];
  int         exp_drops;
  bit         exp_ovf;
  int         n_cmp;
  int         n_bad;

  u_rec_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MIN_LOW(MIN_LOW)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_l   (sys_rst_l),
    .rec_dataH   (rec_dataH),
    .rec_readyH  (rec_readyH),
    .rd_enH      (rd_enH),
    .fifo_dataH  (fifo_dataH),
    .fifo_emptyH (fifo_emptyH),
    .fifo_fullH  (fifo_fullH),
    .fifo_countH (fifo_countH),
    .overflowH   (overflowH),
    .clr_ovfH    (clr_ovfH),
    .drop_cntH   (drop_cntH)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    logic [7:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check({tag, ".count"}, 32'(fifo_countH), 32'(exp_q.size()));
    check({tag, ".empty"}, 32'(fifo_emptyH), 32'(exp_q.size() == 0));
    check({tag, ".full"},  32'(fifo_fullH),  32'(exp_q.size() == DEPTH));
    check({tag, ".head"},  32'(fifo_dataH),  32'(head));
    check({tag, ".ovf"},   32'(overflowH),   32'(exp_ovf));
    check({tag, ".drops"}, 32'(drop_cntH),   32'(exp_drops));
  endtask

  // driver: hold rec_readyH low for 'low' cycles, then raise it with the byte
  task automatic send_byte(input logic [7:0] d, input int low, input bit rd, input bit clr);
    bit rd_eff;
    bit drop;
    for (int i = 0; i < low; i++) begin
      rec_readyH = 1'b0;
      tick();
    end
    rec_readyH = 1'b1;
    rec_dataH  = d;
    rd_enH     = rd;
    clr_ovfH   = clr;
    rd_eff     = rd && (exp_q.size() > 0);
    drop       = 1'b0;
    if (rd_eff) begin
      check("rd_head", 32'(fifo_dataH), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (low >= MIN_LOW) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else drop = 1'b1;
    end
    if (clr) begin
      exp_ovf   = drop;
      exp_drops = drop ? 1 : 0;
    end else if (drop) begin
      exp_ovf = 1'b1;
      if (exp_drops < 255) exp_drops++;
    end
    tick();
    rd_enH   = 1'b0;
    clr_ovfH = 1'b0;
  endtask

  task automatic read_one();
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL read_underflow: got empty model expected data");
    end else begin
      check("read", 32'(fifo_dataH), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    rd_enH = 1'b1;
    tick();
    rd_enH = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_ovfH = 1'b1;
    tick();
    clr_ovfH  = 1'b0;
    exp_ovf   = 1'b0;
    exp_drops = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_ovf = 1'b0;
    exp_drops = 0;
    sys_rst_l  = 1'b0;
    rec_dataH  = 8'h00;
    rec_readyH = 1'b1;
    rd_enH     = 1'b0;
    clr_ovfH   = 1'b0;
    repeat (3) tick();
    check_status("reset");
    sys_rst_l = 1'b1;
    tick();

    // post-reset ready dip of one cycle must not write
    send_byte(8'h3C, 1, 1'b0, 1'b0);
    tick();
    check_status("post_reset_dip");

    // false start, then a genuine long frame
    send_byte(8'h11, 6, 1'b0, 1'b0);
    check_status("false_start");
    send_byte(8'hA5, 160, 1'b0, 1'b0);
    check_status("first_byte");

    // rd_enH while empty after draining is ignored
    read_one();
    rd_enH = 1'b1;
    tick();
    rd_enH = 1'b0;
    check_status("rd_empty");

    // fill with 00..0F; pointers start at 1 so both wrap
    for (int i = 0; i < DEPTH; i++)
      send_byte(8'(i), $urandom_range(MIN_LOW + 8, MIN_LOW), 1'b0, 1'b0);
    check_status("full");

    // overflow: two drops, then clear
    send_byte(8'h55, MIN_LOW, 1'b0, 1'b0);
    send_byte(8'h66, MIN_LOW + 3, 1'b0, 1'b0);
    check_status("overflow2");
    clr_pulse();
    check_status("clr");

    // drop and clear on the same edge: set wins
    send_byte(8'h99, MIN_LOW, 1'b0, 1'b1);
    check_status("clr_vs_drop");
    clr_pulse();

    // full with concurrent read: no overflow, new byte goes last
    send_byte(8'h77, MIN_LOW + 2, 1'b1, 1'b0);
    check_status("full_rd_wr");
    while (exp_q.size() > 0) read_one();
    check_status("drained");

    // empty with concurrent read: read ignored, write lands
    send_byte(8'h88, MIN_LOW, 1'b1, 1'b0);
    check_status("empty_rd_wr");
    read_one();

    // random traffic
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom_range(255, 0)), $urandom_range(MIN_LOW + 4, MIN_LOW), 1'($urandom_range(1, 0)), 1'b0);
      if ($urandom_range(1, 0) == 1 && exp_q.size() > 0) read_one();
    end
    check_status("random");

    // reset mid-reception with a partly filled FIFO
    while (exp_q.size() > 0) read_one();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), MIN_LOW, 1'b0, 1'b0);
    check_status("five");
    rec_readyH = 1'b0;
    repeat (10) tick();
    #2;
    sys_rst_l = 1'b0;
    exp_q.delete();
    #1;
    check_status("async_reset");
    tick();
    sys_rst_l = 1'b1;
    send_byte(8'hE1, 3, 1'b0, 1'b0);
    check_status("short_after_reset");
    send_byte(8'hE2, MIN_LOW, 1'b0, 1'b0);
    check_status("valid_after_reset");
    read_one();
    check_status("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
